// File: rtl/seq_detect_n.sv
// Programmable Mealy sequence detector over WIDTH-bit symbols with masked pattern compare.
// Define SEQDET_COUNT_EN to build the saturating match counter; otherwise match_count/count_sat tie to 0.
module seq_detect_n #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 3,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_sym,
  input  logic                   cfg_we,
  input  logic [WIDTH*DEPTH-1:0] cfg_pattern,
  input  logic [WIDTH*DEPTH-1:0] cfg_mask,
  input  logic                   cfg_overlap,
  output logic                   match,
  output logic                   match_q,
  output logic [CNT_W-1:0]       match_count,
  output logic                   count_sat
);

  // state | meaning
  // FILL  | fewer than DEPTH-1 symbols accepted since the last clear
  // ARMED | history holds DEPTH-1 symbols; each valid symbol is compared

  localparam int HD = (DEPTH > 1) ? DEPTH - 1 : 1;
  localparam int FW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = WIDTH * DEPTH;

  typedef enum logic {FILL, ARMED} state_t;
  localparam state_t CLR_STATE = (DEPTH > 1) ? FILL : ARMED;

  state_t           state, state_n;
  logic [FW-1:0]    fill, fill_n;
  logic [PW-1:0]    pat_q, mask_q;
  logic             ovl_q;
  logic [WIDTH-1:0] hist [HD];
  logic [PW-1:0]    window;
  logic             hit, accept, hist_clr, hist_shift;

  // slot 0 is the oldest held symbol, the top slot is the live input
  always_comb begin
    window = '0;
    for (int k = 0; k < DEPTH - 1; k++) window[k*WIDTH +: WIDTH] = hist[k];
    window[(DEPTH-1)*WIDTH +: WIDTH] = in_sym;
  end

  assign hit    = ((window ^ pat_q) & mask_q) == '0;
  assign accept = in_valid & ~cfg_we & ~reset;
  assign match  = (state == ARMED) & accept & hit;

  always_comb begin
    state_n    = state;
    fill_n     = fill;
    hist_clr   = 1'b0;
    hist_shift = 1'b0;
    if (cfg_we) begin
      state_n  = CLR_STATE;
      fill_n   = '0;
      hist_clr = 1'b1;
    end else if (accept) begin
      case (state)
        FILL: begin
          hist_shift = 1'b1;
          fill_n     = fill + 1'b1;
          if (fill == FW'(DEPTH - 2)) state_n = ARMED;
        end
        ARMED: begin
          if (match && !ovl_q) begin
            state_n  = CLR_STATE;
            fill_n   = '0;
            hist_clr = 1'b1;
          end else begin
            hist_shift = 1'b1;
          end
        end
        default: state_n = CLR_STATE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLR_STATE;
      fill  <= '0;
    end else begin
      state <= state_n;
      fill  <= fill_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q  <= '0;
      mask_q <= '1;
      ovl_q  <= 1'b1;
    end else if (cfg_we) begin
      pat_q  <= cfg_pattern;
      mask_q <= cfg_mask;
      ovl_q  <= cfg_overlap;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || hist_clr) begin
      for (int i = 0; i < HD; i++) hist[i] <= '0;
    end else if (hist_shift) begin
      for (int i = 0; i < HD - 1; i++) hist[i] <= hist[i+1];
      hist[HD-1] <= in_sym;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) match_q <= 1'b0;
    else       match_q <= match;
  end

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || cfg_we)        cnt_q <= '0;
    else if (match && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
  end

  assign match_count = cnt_q;
  assign count_sat   = &cnt_q;
`else
  assign match_count = '0;
  assign count_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detect_n.sv
// Self-checking bench for seq_detect_n: directed scenarios plus randomized traffic against a queue model.
module tb_seq_detect_n;
  localparam int WIDTH = 2;
  localparam int DEPTH = 3;
  localparam int CNT_W = 3;
  localparam int PW    = WIDTH * DEPTH;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk, reset, in_valid, cfg_we, cfg_overlap;
  logic [WIDTH-1:0] in_sym;
  logic [PW-1:0]    cfg_pattern, cfg_mask;
  logic             match, match_q, count_sat;
  logic [CNT_W-1:0] match_count;

  seq_detect_n #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sym(in_sym),
    .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
    .cfg_overlap(cfg_overlap), .match(match), .match_q(match_q),
    .match_count(match_count), .count_sat(count_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // reference: symbols accepted since the last clear, newest at the back
  logic [WIDTH-1:0] sq[$];
  logic [PW-1:0]    m_pat, m_mask;
  logic             m_ovl, m_mq;
  int               m_cnt;
  bit               started = 0;

  function automatic logic model_match();
    logic [WIDTH-1:0] s, p, m;
    if (reset || cfg_we || !in_valid) return 1'b0;
    if (sq.size() < DEPTH - 1) return 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      s = (k == DEPTH - 1) ? in_sym : sq[sq.size() - (DEPTH - 1) + k];
      p = WIDTH'(m_pat >> (WIDTH * k));
      m = WIDTH'(m_mask >> (WIDTH * k));
      if (((s ^ p) & m) != '0) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int cnt_of(input int n);
`ifdef SEQDET_COUNT_EN
    return (n > MAXC) ? MAXC : n;
`else
    return 0;
`endif
  endfunction

  always @(posedge clk) begin : mdl
    logic em;
    em = model_match();
    m_mq = em;
    if (reset) begin
      sq.delete();
      m_pat = '0; m_mask = '1; m_ovl = 1'b1; m_cnt = 0;
      started = 1;
    end else if (cfg_we) begin
      sq.delete();
      m_pat = cfg_pattern; m_mask = cfg_mask; m_ovl = cfg_overlap; m_cnt = 0;
    end else if (in_valid) begin
      if (em) m_cnt = m_cnt + 1;
      if (em && !m_ovl) sq.delete();
      else sq.push_back(in_sym);
      if (sq.size() > DEPTH - 1) void'(sq.pop_front());
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      vectors++;
      chk("match", 32'(match), 32'(model_match()));
      chk("match_q", 32'(match_q), 32'(m_mq));
      chk("match_count", 32'(match_count), 32'(cnt_of(m_cnt)));
      chk("count_sat", 32'(count_sat), 32'(cnt_of(m_cnt) == MAXC && cnt_of(m_cnt) != 0));
    end
  end

  task automatic step(input logic r, input logic v, input logic [WIDTH-1:0] s);
    @(posedge clk); #1;
    reset = r; in_valid = v; in_sym = s; cfg_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic cfg(input logic [PW-1:0] p, input logic [PW-1:0] m, input logic o,
                     input logic v, input logic [WIDTH-1:0] s);
    @(posedge clk); #1;
    reset = 1'b0; cfg_we = 1'b1; cfg_pattern = p; cfg_mask = m; cfg_overlap = o;
    in_valid = v; in_sym = s;
    @(negedge clk);
    chk("cfg_forces_no_match", 32'(match), 32'(0));
  endtask

  localparam logic [PW-1:0] PAT_BASIC = 6'b10_11_01;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_sym = '0; cfg_we = 1'b0;
    cfg_pattern = '0; cfg_mask = '0; cfg_overlap = 1'b0;
    step(1, 0, 0);
    step(1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    chk("idle_match", 32'(match), 32'(0));
    chk("idle_match_q", 32'(match_q), 32'(0));
    chk("idle_count", 32'(match_count), 32'(0));
    chk("idle_sat", 32'(count_sat), 32'(0));

    // reset pattern 0 with full mask: 00,00,00 matches, 00,00,01 does not
    step(0, 1, 2'b00); step(0, 1, 2'b00); step(0, 1, 2'b00);
    chk("rst_zero_match", 32'(match), 32'(1));
    step(0, 1, 2'b01);
    chk("rst_mask_ones", 32'(match), 32'(0));

    cfg(PAT_BASIC, '1, 1'b1, 1'b0, 2'b00);
    step(0, 1, 2'b01); step(0, 1, 2'b11); step(0, 1, 2'b10);
    chk("basic_match", 32'(match), 32'(1));
    step(0, 0, 0);
    chk("basic_match_q", 32'(match_q), 32'(1));
    chk("basic_count", 32'(match_count), 32'(cnt_of(1)));
    step(0, 1, 2'b01); step(0, 1, 2'b11); step(0, 1, 2'b00);
    chk("basic_nomatch", 32'(match), 32'(0));

    cfg('1, '1, 1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 2'b11);
      chk("ovl_match", 32'(match), 32'(i >= 2));
    end
    step(0, 0, 0);
    chk("ovl_count", 32'(match_count), 32'(cnt_of(4)));

    cfg('1, '1, 1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 2'b11);
      chk("novl_match", 32'(match), 32'(i == 2 || i == 5));
    end
    step(0, 0, 0);
    chk("novl_count", 32'(match_count), 32'(cnt_of(2)));

    cfg(PAT_BASIC, 6'b11_00_11, 1'b1, 1'b0, 2'b00);
    step(0, 1, 2'b01); step(0, 0, 2'b11); step(0, 0, 2'b10);
    step(0, 1, 2'b00); step(0, 1, 2'b10);
    chk("dontcare_gap_match", 32'(match), 32'(1));

    cfg(PAT_BASIC, '1, 1'b1, 1'b0, 2'b00);
    step(0, 1, 2'b01); step(0, 1, 2'b11);
    cfg(PAT_BASIC, '1, 1'b1, 1'b1, 2'b10);
    step(0, 1, 2'b10);
    chk("midcfg_no_match", 32'(match), 32'(0));
    chk("midcfg_count", 32'(match_count), 32'(0));
    step(0, 1, 2'b01); step(0, 1, 2'b11); step(0, 1, 2'b10);
    chk("midcfg_rematch", 32'(match), 32'(1));

    // all-zero mask: every armed symbol matches, counter saturates
    cfg('0, '0, 1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, WIDTH'($urandom));
      chk("zero_mask_match", 32'(match), 32'(i >= 2));
    end
    step(0, 0, 0);
    chk("sat_count", 32'(match_count), 32'(cnt_of(8)));
    chk("sat_flag", 32'(count_sat), 32'(cnt_of(8) == MAXC));

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0)
        cfg(PW'($urandom), PW'($urandom & $urandom), 1'($urandom),
            1'($urandom), WIDTH'($urandom));
      else
        step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, WIDTH'($urandom));
    end
    step(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
